// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM states, skid payload,
// bubble encoding and PC helpers.
package fetch_unit_pkg;

  localparam int unsigned INSTR_BYTES  = 4;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_pkt_t;

  // Next sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'(INSTR_BYTES);
  endfunction

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus. The fetch unit is the master;
// ack and rdata are valid in the same cycle.
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;

  modport master (output imemReq, output imemAddr, input imemAck, input imemRdata);
  modport slave  (input imemReq, input imemAddr, output imemAck, output imemRdata);
endinterface

// File: rtl/fetch_unit_skid.sv
// One-entry skid buffer: catches a word that returns from memory while the
// IF/ID slot is still stalled, so the request can complete without loss.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_unload,
  input  logic       i_clear,
  input  fetch_pkt_t i_pkt,
  output fetch_pkt_t o_pkt,
  output logic       o_valid
);

  fetch_pkt_t r_pkt;
  logic       r_valid;

  // Clear (redirect) beats load; unload frees the entry after handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt   <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pkt   <= i_pkt;
      r_valid <= 1'b1;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_pkt   = r_pkt;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request FSM and the producer side of the
// IF/ID register. Handles downstream stall via a one-entry skid buffer and
// redirects with a DROP state that lets an outstanding request finish.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] BUBBLE   = BUBBLE_INSTR
)(
  input  logic                clk,
  input  logic                rstn,          // active-high synchronous reset
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirectAddr,
  fetch_unit_if.master        imem,
  output logic [31:0]         AddrOut,
  output logic [31:0]         instrOut,
  output logic                instrValid
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_req, w_req_nxt;
  logic [31:0]  r_addr, w_addr_nxt;
  logic [31:0]  r_addr_out, w_addr_out_nxt;
  logic [31:0]  r_instr_out, w_instr_out_nxt;
  logic         r_valid, w_valid_nxt;

  logic         w_skid_load, w_skid_unload, w_skid_clear;
  fetch_pkt_t   w_skid_in, w_skid_out;
  logic         w_skid_valid;

  logic [31:0]  w_tgt;
  logic         w_slot_free;

  assign w_tgt       = word_align(redirectAddr);
  // IF/ID can take a new word if empty or being consumed this edge.
  assign w_slot_free = !r_valid || !stall;

  assign w_skid_in.addr  = r_addr;
  assign w_skid_in.instr = imem.imemRdata;

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rstn),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_pkt    (w_skid_in),
    .o_pkt    (w_skid_out),
    .o_valid  (w_skid_valid)
  );

  // Next-state and datapath decisions; redirect overrides everything below.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_nxt       = r_req;
    w_addr_nxt      = r_addr;
    w_addr_out_nxt  = r_addr_out;
    w_instr_out_nxt = r_instr_out;
    w_valid_nxt     = r_valid;
    w_skid_load     = 1'b0;
    w_skid_unload   = 1'b0;
    w_skid_clear    = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_nxt = REQ;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = r_pc;
      end
      REQ: begin
        if (imem.imemAck) begin
          if (w_slot_free) begin
            w_addr_out_nxt  = r_addr;
            w_instr_out_nxt = imem.imemRdata;
            w_valid_nxt     = 1'b1;
            w_pc_nxt        = pc_inc(r_pc);
            w_addr_nxt      = pc_inc(r_pc);
          end else begin
            // Slot still stalled: park the word and stop requesting.
            w_skid_load = 1'b1;
            w_req_nxt   = 1'b0;
            w_state_nxt = HOLD;
          end
        end else if (r_valid && !stall) begin
          w_valid_nxt     = 1'b0;
          w_instr_out_nxt = BUBBLE;
        end
      end
      HOLD: begin
        if (!stall) begin
          w_addr_out_nxt  = w_skid_out.addr;
          w_instr_out_nxt = w_skid_out.instr;
          w_valid_nxt     = w_skid_valid;
          w_skid_unload   = 1'b1;
          w_pc_nxt        = pc_inc(r_pc);
          w_addr_nxt      = pc_inc(r_pc);
          w_req_nxt       = 1'b1;
          w_state_nxt     = REQ;
        end
      end
      DROP: begin
        // Old request must finish on its original address; its data is dead.
        if (imem.imemAck) begin
          w_addr_nxt  = r_pc;
          w_state_nxt = REQ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase

    if (redirect) begin
      w_pc_nxt        = w_tgt;
      w_valid_nxt     = 1'b0;
      w_instr_out_nxt = BUBBLE;
      w_addr_out_nxt  = '0;
      w_skid_clear    = 1'b1;
      w_skid_load     = 1'b0;
      w_skid_unload   = 1'b0;
      w_req_nxt       = 1'b1;
      if ((r_state == REQ || r_state == DROP) && !imem.imemAck) begin
        w_addr_nxt  = r_addr;
        w_state_nxt = DROP;
      end else begin
        w_addr_nxt  = w_tgt;
        w_state_nxt = REQ;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rstn) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // PC and imem request registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_pc   <= RESET_PC;
      r_req  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_req  <= w_req_nxt;
      r_addr <= w_addr_nxt;
    end
  end

  // IF/ID producer registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_addr_out  <= '0;
      r_instr_out <= BUBBLE;
      r_valid     <= 1'b0;
    end else begin
      r_addr_out  <= w_addr_out_nxt;
      r_instr_out <= w_instr_out_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign imem.imemReq  = r_req;
  assign imem.imemAddr = r_addr;
  assign AddrOut       = r_addr_out;
  assign instrOut      = r_instr_out;
  assign instrValid    = r_valid;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and the producer side of the IF/ID pipeline register. It holds the program counter, issues word requests to instruction memory over a request/acknowledge handshake, and presents the fetched address and instruction to IF/ID. It honours downstream stall and later-stage redirect (branch/jump) with a small state machine and a one-entry skid buffer.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- BUBBLE, 32'h0000_0000, instruction value driven when no valid instruction is presented

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  synchronous reset, active-high (asserted = 1 resets on the next rising edge)
- stall  in  1  IF/ID cannot accept; the presented instruction must be held
- redirect  in  1  later stage requests fetch restart
- redirectAddr  in  32  restart target; bits [1:0] ignored and forced to 0
- imemReq  out  1  fetch request
- imemAddr  out  32  word address of the request; stable while imemReq=1 until imemAck
- imemAck  in  1  request completed this cycle; imemRdata valid in the same cycle
- imemRdata  in  32  fetched instruction
- AddrOut  out  32  PC of the presented instruction (to IF/ID AddrIn)
- instrOut  out  32  presented instruction (to IF/ID instrIn)
- instrValid  out  1  AddrOut/instrOut hold a real instruction

## Operation
- States: IDLE, REQ, HOLD, DROP.
- Reset (rstn=1 at edge): state=IDLE, pc=RESET_PC, imemReq=0, imemAddr=0, AddrOut=0, instrOut=BUBBLE, instrValid=0, skid empty. This overrides everything, including during an outstanding request.
- IDLE: go to REQ; imemReq=1, imemAddr=pc.
- REQ, imemAck=1, no redirect:
  - If the output slot is free (instrValid=0 or stall=0): load AddrOut=imemAddr, instrOut=imemRdata, instrValid=1; pc+=4; stay in REQ; the next request is issued with imemAddr=pc+4 from the next cycle.
  - Otherwise, write {imemAddr, imemRdata} into the skid buffer; imemReq=0; go to HOLD.
- REQ, imemAck=0: hold imemAddr. If instrValid=1 and stall=0, clear instrValid and set instrOut=BUBBLE.
- HOLD: when stall=0, move the skid buffer to the outputs, clear the skid, pc+=4, and go to REQ.
- Consumption: an instruction counts as accepted at any edge with instrValid=1 and stall=0.
- Redirect (priority over stall and ack):
  - At the edge: pc=redirectAddr&~3, instrValid=0, instrOut=BUBBLE, AddrOut=0, skid cleared.
  - If in REQ with imemAck=0: go to DROP (the address must stay stable).
  - Otherwise, any data acked this cycle is discarded; go to REQ with imemAddr=redirect target.
- DROP: keep imemReq=1 on the old address. On imemAck, discard the data and go to REQ at pc. A second redirect in DROP overwrites pc and stays in DROP.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset release: imemReq rises one cycle after the last reset edge (IDLE→REQ).
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle.
- Fetch latency: instruction visible on the outputs at the edge after imemAck.
- Redirect: outputs show a bubble the cycle after redirect; the target request is issued the same cycle if no request is outstanding, otherwise the cycle after the old ack.
- No combinational path from stall or redirect to imemAddr. imemReq is registered.

## Structure
- The shared cpu package holds the state enum (IDLE/REQ/HOLD/DROP), the BUBBLE constant, and INSTR_BYTES=4.
- One sub-module: fetch_skid, a one-entry {addr, instr, valid} buffer with load/unload/clear.
- The PC register and FSM live in the top level.

## Test plan
- Reset: rstn high for 2 cycles, then low → all outputs 0/BUBBLE; imemReq=1 with imemAddr=0 on cycle 2.
- Zero-wait stream: memory returns addr^32'hA5A5_0000 → AddrOut sequence 0, 4, 8, 12 on consecutive cycles with instrValid=1 throughout.
- Stall with ack: stall=1 while holding addr 4 and ack for addr 8 → outputs hold 4; HOLD state and imemReq=0; after stall drops, outputs show 8, then a request for 12.
- Redirect during a 3-cycle-wait request at 0x10, redirectAddr=0x103 → DROP; old data is never presented; next imemAddr=0x100; first valid AddrOut=0x100.
- Simultaneous redirect+stall+ack → redirect wins: instrValid=0 next cycle, data discarded, next request to the target.
- Wrap: RESET_PC=32'hFFFF_FFF8 → AddrOut sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
